cam_table_writer: RTL and testbench
===================================

Name: cam_table_writer

Overview:
- Maintenance and write side of the content-addressable lookup path.
- Accepts write (learn/update) and delete commands over a valid/ready handshake.
- Scans a DEPTH-entry table one slot per cycle to find a matching key or the first free slot, then commits the change.
- The full table (valid/key/data per entry) is exported flat so search-side logic can compare against it combinationally.

Parameters:
- n, 8, data width per entry
- m, 4, key width per entry
- DEPTH, 8, number of entries (power of 2, >= 2)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  1  0 = write, 1 = delete
- cmd_key  in  m  key to write/delete
- cmd_data  in  n  data for write; ignored on delete
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  2  00 NEW, 01 UPDATED, 10 FULL, 11 NOT_FOUND
- rsp_index  out  $clog2(DEPTH)  slot affected; 0 for FULL/NOT_FOUND
- tbl_valid  out  DEPTH  per-entry valid bits
- tbl_key  out  DEPTH*m  entry i key at bits [i*m +: m]
- tbl_data  out  DEPTH*n  entry i data at bits [i*n +: n]
- count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Interface: clock and reset are named clk and rst. One clock; reset is synchronous and active-high.
- Reset values: all tbl_valid, tbl_key, tbl_data = 0; count = 0; rsp_valid = 0; rsp_status = 0; rsp_index = 0; state = IDLE; cmd_ready = 1 in the cycle after reset is released.
- Reset mid-operation: an in-flight command is abandoned, produces no response, and leaves no table change.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_key, cmd_op and cmd_data are latched at that edge. cmd_valid while not ready is ignored; no queuing.
- IDLE: cmd_ready = 1. On accept, go to SCAN with scan index = 0, hit = 0, free_found = 0.
- SCAN: cmd_ready = 0. One entry is examined per cycle at the scan index.
  - Valid entry with key equal to the latched key: record hit and hit index (first match wins).
  - Invalid entry: record the first free index.
  - After index DEPTH-1, go to COMMIT.
  - Scan index wraps to 0 only on a new accept.
- COMMIT: one cycle. Table update and response registers are written at the end of this cycle.
  - write + hit: overwrite data at hit index; status UPDATED; count unchanged.
  - write + miss + free_found: set valid, key, data at free index; status NEW; count+1.
  - write + miss + no free: no change; status FULL.
  - delete + hit: clear valid at hit index (key/data keep their contents); status NOT_FOUND is not used; status UPDATED; count-1.
  - delete + miss: no change; status NOT_FOUND.
  - Next state is IDLE.
- Response: rsp_valid is high exactly one cycle, the cycle after COMMIT. The updated table is visible in that same cycle. cmd_ready is also high in that cycle.
- Latency: accept edge at cycle T; rsp_valid high in cycle T+DEPTH+2; back-to-back throughput is one command per DEPTH+2 cycles.
- Write to a full table whose key is already present returns UPDATED, not FULL.
- Key compare is exact over all m bits. Data is never compared.
- count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: CAM_TABLE_WRITER_EARLY_EXIT_EN.
- Defined: SCAN goes to COMMIT on the cycle a hit is found.
  - Latency for a hit at index k is k+3 cycles (accept to rsp_valid).
  - Misses are unchanged at DEPTH+2.
- Undefined: fixed latency DEPTH+2 for all commands, as above.
- Table contents and status codes are identical in both builds.

Decomposition:
- Package cam_pkg holds:
  - status codes NEW/UPDATED/FULL/NOT_FOUND (2-bit)
  - op codes OP_WRITE/OP_DELETE
  - FSM state enum IDLE/SCAN/COMMIT
- One sub-module: cam_entry, a single slot register (valid/key/data) with set, update and clear enables plus synchronous reset. Instantiated DEPTH times via generate.
- The FSM, scan index and response logic live in the top module.

Test Plan:
- Reset, then write key 4'h3 / data 8'hA5 → rsp_valid at T+10 (DEPTH=8), status NEW, index 0, tbl_valid=8'h01, count=1.
- Write key 3 again with data 8'h5A → status UPDATED, index 0, entry 0 data 8'h5A, count stays 1.
- Fill slots with keys 0..7, then write key 4'hF → FULL, index 0, table unchanged; write key 4'h2 → UPDATED.
- Delete key 4'h9 on a table lacking it → NOT_FOUND, no change; delete key 3 → UPDATED, that valid bit clears, count-1; next write reuses that slot (NEW, same index).
- Assert cmd_valid during SCAN → cmd_ready=0, command ignored, single rsp_valid pulse; assert rst during SCAN → no response, table and count return to 0.
- With CAM_TABLE_WRITER_EARLY_EXIT_EN, key present at index 2 → rsp_valid at T+5; miss still at T+10.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types for the CAM table writer: response status codes,
//               command op codes and the writer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

  // Response status returned with every completed command
  typedef enum logic [1:0] {
    RSP_NEW       = 2'b00,
    RSP_UPDATED   = 2'b01,
    RSP_FULL      = 2'b10,
    RSP_NOT_FOUND = 2'b11
  } rsp_status_e;

  // Command op codes carried on cmd_op
  typedef enum logic {
    OP_WRITE  = 1'b0,
    OP_DELETE = 1'b1
  } cam_op_e;

  // Writer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage : cam_pkg
`default_nettype wire

// File: rtl/cam_entry.sv
`default_nettype none
// ============================================================================
// Module      : cam_entry
// Description : One CAM table slot holding valid/key/data.
//               set_en : load valid=1, key and data
//               upd_en : load data only (key already matches)
//               clr_en : drop valid, key and data keep their contents
//               Enables are mutually exclusive in normal use; set_en has
//               priority, then upd_en, then clr_en.
// Ports       : clk, rst (sync, active-high), set_en, upd_en, clr_en,
//               wr_key[M], wr_data[N], valid, key[M], data[N]
// Revision    : 1.0 - initial release
// ============================================================================
module cam_entry #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  logic         upd_en,
  input  logic         clr_en,
  input  logic [M-1:0] wr_key,
  input  logic [N-1:0] wr_data,
  output logic         valid,
  output logic [M-1:0] key,
  output logic [N-1:0] data
);

  logic         valid_q, valid_d;
  logic [M-1:0] key_q,   key_d;
  logic [N-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    if (set_en) begin
      valid_d = 1'b1;
      key_d   = wr_key;
      data_d  = wr_data;
    end else if (upd_en) begin
      data_d  = wr_data;
    end else if (clr_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign key   = key_q;
  assign data  = data_q;

endmodule : cam_entry
`default_nettype wire

// File: rtl/cam_table_writer.sv
`default_nettype none
// ============================================================================
// Module      : cam_table_writer
// Description : Write/maintenance side of a CAM lookup path. Accepts write
//               (learn/update) and delete commands over valid/ready, scans
//               the table one slot per cycle for a matching key and the first
//               free slot, then commits the change in a single COMMIT cycle.
//               The whole table is exported flat for combinational search.
// Config      : `define CAM_TABLE_WRITER_EARLY_EXIT_EN leaves SCAN on the
//               cycle a key hit is found (hit at slot k -> k+3 cycle latency).
//               Undefined: every command takes DEPTH+2 cycles.
// Ports       : clk, rst (sync, active-high)
//               cmd_valid, cmd_ready, cmd_op, cmd_key[M], cmd_data[N]
//               rsp_valid, rsp_status[2], rsp_index[$clog2(DEPTH)]
//               tbl_valid[DEPTH], tbl_key[DEPTH*M], tbl_data[DEPTH*N]
//               count[$clog2(DEPTH)+1]
// Revision    : 1.0 - initial release
// ============================================================================
module cam_table_writer
  import cam_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [M-1:0]               cmd_key,
  input  logic [N-1:0]               cmd_data,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_status,
  output logic [$clog2(DEPTH)-1:0]   rsp_index,
  output logic [DEPTH-1:0]           tbl_valid,
  output logic [DEPTH*M-1:0]         tbl_key,
  output logic [DEPTH*N-1:0]         tbl_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              IW        = $clog2(DEPTH);
  localparam int              CW        = IW + 1;
  localparam logic [IW-1:0]   IDX_LAST  = IW'(DEPTH - 1);
  localparam logic [CW-1:0]   COUNT_MAX = CW'(DEPTH);

  // FSM and scan bookkeeping
  state_e        state_q,      state_d;
  logic [IW-1:0] scan_idx_q,   scan_idx_d;
  logic          hit_q,        hit_d;
  logic [IW-1:0] hit_idx_q,    hit_idx_d;
  logic          free_q,       free_d;
  logic [IW-1:0] free_idx_q,   free_idx_d;

  // Latched command
  cam_op_e       op_q,         op_d;
  logic [M-1:0]  key_q,        key_d;
  logic [N-1:0]  data_q,       data_d;

  // Response and occupancy
  logic          rsp_valid_q,  rsp_valid_d;
  rsp_status_e   rsp_status_q, rsp_status_d;
  logic [IW-1:0] rsp_index_q,  rsp_index_d;
  logic [CW-1:0] count_q,      count_d;

  // Slot interface
  logic [DEPTH-1:0] ent_valid;
  logic [M-1:0]     ent_key  [DEPTH];
  logic [N-1:0]     ent_data [DEPTH];
  logic [DEPTH-1:0] set_en;
  logic [DEPTH-1:0] upd_en;
  logic [DEPTH-1:0] clr_en;

  logic             cur_valid;
  logic             cur_match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    cam_entry #(
      .N (N),
      .M (M)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .set_en  (set_en[i]),
      .upd_en  (upd_en[i]),
      .clr_en  (clr_en[i]),
      .wr_key  (key_q),
      .wr_data (data_q),
      .valid   (ent_valid[i]),
      .key     (ent_key[i]),
      .data    (ent_data[i])
    );

    assign tbl_key [i*M +: M] = ent_key[i];
    assign tbl_data[i*N +: N] = ent_data[i];
  end

  // Slot currently under examination
  assign cur_valid = ent_valid[scan_idx_q];
  assign cur_match = cur_valid && (ent_key[scan_idx_q] == key_q);

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    free_d       = free_q;
    free_idx_d   = free_idx_q;
    op_d         = op_q;
    key_d        = key_q;
    data_d       = data_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_index_d  = rsp_index_q;
    count_d      = count_q;
    set_en       = '0;
    upd_en       = '0;
    clr_en       = '0;
    cmd_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d       = cam_op_e'(cmd_op);
          key_d      = cmd_key;
          data_d     = cmd_data;
          scan_idx_d = '0;
          hit_d      = 1'b0;
          hit_idx_d  = '0;
          free_d     = 1'b0;
          free_idx_d = '0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        // Only the first match and the first free slot are recorded
        if (cur_match) begin
          if (!hit_q) begin
            hit_d     = 1'b1;
            hit_idx_d = scan_idx_q;
          end
        end else if (!cur_valid && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = scan_idx_q;
        end

`ifdef CAM_TABLE_WRITER_EARLY_EXIT_EN
        if (cur_match || (scan_idx_q == IDX_LAST)) begin
          state_d = COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + IW'(1);
        end
`else
        if (scan_idx_q == IDX_LAST) begin
          state_d = COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + IW'(1);
        end
`endif
      end

      COMMIT: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_index_d = '0;
        if (op_q == OP_WRITE) begin
          if (hit_q) begin
            upd_en[hit_idx_q] = 1'b1;
            rsp_status_d      = RSP_UPDATED;
            rsp_index_d       = hit_idx_q;
          end else if (free_q) begin
            set_en[free_idx_q] = 1'b1;
            rsp_status_d       = RSP_NEW;
            rsp_index_d        = free_idx_q;
            if (count_q != COUNT_MAX) begin
              count_d = count_q + CW'(1);
            end
          end else begin
            rsp_status_d = RSP_FULL;
          end
        end else begin
          if (hit_q) begin
            clr_en[hit_idx_q] = 1'b1;
            rsp_status_d      = RSP_UPDATED;
            rsp_index_d       = hit_idx_q;
            if (count_q != '0) begin
              count_d = count_q - CW'(1);
            end
          end else begin
            rsp_status_d = RSP_NOT_FOUND;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scan_idx_q   <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      free_q       <= 1'b0;
      free_idx_q   <= '0;
      op_q         <= OP_WRITE;
      key_q        <= '0;
      data_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_NEW;
      rsp_index_q  <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      free_q       <= free_d;
      free_idx_q   <= free_idx_d;
      op_q         <= op_d;
      key_q        <= key_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_index_q  <= rsp_index_d;
      count_q      <= count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_index  = rsp_index_q;
  assign tbl_valid  = ent_valid;
  assign count      = count_q;

endmodule : cam_table_writer
`default_nettype wire

// File: tb/tb_cam_table_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_table_writer
// Description : Directed self-checking bench for cam_table_writer
//               (DEPTH=8, m=4, n=8). Expected table contents are kept in a
//               small hand-maintained model; latencies and statuses are
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_table_writer;

  localparam logic [1:0] S_NEW  = 2'b00;
  localparam logic [1:0] S_UPD  = 2'b01;
  localparam logic [1:0] S_FULL = 2'b10;
  localparam logic [1:0] S_NF   = 2'b11;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [3:0]  cmd_key;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_index;
  logic [7:0]  tbl_valid;
  logic [31:0] tbl_key;
  logic [63:0] tbl_data;
  logic [3:0]  count;

  int vectors;
  int miscompares;

  // Expected table model
  logic [7:0] exp_valid;
  logic [3:0] exp_key  [8];
  logic [7:0] exp_data [8];

  cam_table_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_key    (cmd_key),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .rsp_index  (rsp_index),
    .tbl_valid  (tbl_valid),
    .tbl_key    (tbl_key),
    .tbl_data   (tbl_data),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pack_key();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = exp_key[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_data();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = exp_data[i];
    return v;
  endfunction

  task automatic clear_model();
    exp_valid = '0;
    for (int i = 0; i < 8; i++) begin
      exp_key[i]  = '0;
      exp_data[i] = '0;
    end
  endtask

  // Issue one command from a negedge; returns at the negedge of the response
  // cycle. lat = n where rsp_valid is seen in cycle T+n (T = accept cycle).
  task automatic do_cmd(input logic op, input logic [3:0] key, input logic [7:0] data,
                        output logic [1:0] st, output logic [2:0] idx,
                        output int lat, output time acc_t);
    int guard;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    cmd_data  = data;
    guard     = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (guard >= 50) lat = -1;
    st  = rsp_status;
    idx = rsp_index;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_key   = '0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_model();
    vectors++;
    if (tbl_valid !== 8'h00 || tbl_key !== 32'h0 || tbl_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_table: valid=%h key=%h data=%h required all zero", tbl_valid, tbl_key, tbl_data);
    end
    vectors++;
    if (count !== 4'd0 || rsp_valid !== 1'b0 || rsp_status !== 2'b00 || rsp_index !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_rsp: count=%0d rsp_valid=%b status=%b index=%0d required 0/0/00/0",
               count, rsp_valid, rsp_status, rsp_index);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_new();
    logic [1:0] st; logic [2:0] idx; int lat; time t;
    do_cmd(1'b0, 4'h3, 8'hA5, st, idx, lat, t);
    vectors++;
    if (lat !== 10) begin
      miscompares++;
      $display("FAIL new_latency: got %0d required 10", lat);
    end
    vectors++;
    if (st !== S_NEW || idx !== 3'd0) begin
      miscompares++;
      $display("FAIL new_rsp: status=%b index=%0d required 00/0", st, idx);
    end
    vectors++;
    if (tbl_valid !== 8'h01 || count !== 4'd1 || tbl_key[3:0] !== 4'h3 || tbl_data[7:0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL new_table: valid=%h count=%0d key0=%h data0=%h required 01/1/3/a5",
               tbl_valid, count, tbl_key[3:0], tbl_data[7:0]);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL new_ready_in_rsp: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL new_pulse_width: rsp_valid=%b one cycle later, required 0", rsp_valid);
    end
    exp_valid[0] = 1'b1; exp_key[0] = 4'h3; exp_data[0] = 8'hA5;
  endtask

  task automatic test_update();
    logic [1:0] st; logic [2:0] idx; int lat; time t;
    int exp_lat;
`ifdef CAM_TABLE_WRITER_EARLY_EXIT_EN
    exp_lat = 3;
`else
    exp_lat = 10;
`endif
    do_cmd(1'b0, 4'h3, 8'h5A, st, idx, lat, t);
    exp_data[0] = 8'h5A;
    vectors++;
    if (st !== S_UPD || idx !== 3'd0 || lat !== exp_lat) begin
      miscompares++;
      $display("FAIL update_rsp: status=%b index=%0d lat=%0d required 01/0/%0d", st, idx, lat, exp_lat);
    end
    vectors++;
    if (tbl_data[7:0] !== 8'h5A || count !== 4'd1 || tbl_valid !== 8'h01) begin
      miscompares++;
      $display("FAIL update_table: data0=%h count=%0d valid=%h required 5a/1/01", tbl_data[7:0], count, tbl_valid);
    end
  endtask

  task automatic test_full();
    logic [1:0] st; logic [2:0] idx; int lat; time t;
    logic [1:0] es; logic [2:0] ei;
    int exp_lat;
    // Keys 0..7: key 3 already lives in slot 0, others take the first free slot
    for (int k = 0; k < 8; k++) begin
      do_cmd(1'b0, 4'(k), 8'h10 + 8'(k), st, idx, lat, t);
      es = (k == 3) ? S_UPD : S_NEW;
      ei = (k < 3) ? 3'(k + 1) : (k == 3) ? 3'd0 : 3'(k);
      vectors++;
      if (st !== es || idx !== ei) begin
        miscompares++;
        $display("FAIL fill_key%0d: status=%b index=%0d required %b/%0d", k, st, idx, es, ei);
      end
      exp_valid[ei] = 1'b1; exp_key[ei] = 4'(k); exp_data[ei] = 8'h10 + 8'(k);
    end
    vectors++;
    if (count !== 4'd8 || tbl_valid !== 8'hFF || tbl_key !== pack_key() || tbl_data !== pack_data()) begin
      miscompares++;
      $display("FAIL fill_table: count=%0d valid=%h key=%h data=%h required 8/ff/%h/%h",
               count, tbl_valid, tbl_key, tbl_data, pack_key(), pack_data());
    end
    do_cmd(1'b0, 4'hF, 8'hEE, st, idx, lat, t);
    vectors++;
    if (st !== S_FULL || idx !== 3'd0 || lat !== 10) begin
      miscompares++;
      $display("FAIL full_rsp: status=%b index=%0d lat=%0d required 10/0/10", st, idx, lat);
    end
    vectors++;
    if (count !== 4'd8 || tbl_valid !== 8'hFF || tbl_key !== pack_key() || tbl_data !== pack_data()) begin
      miscompares++;
      $display("FAIL full_unchanged: count=%0d valid=%h key=%h data=%h", count, tbl_valid, tbl_key, tbl_data);
    end
`ifdef CAM_TABLE_WRITER_EARLY_EXIT_EN
    exp_lat = 6;
`else
    exp_lat = 10;
`endif
    do_cmd(1'b0, 4'h2, 8'hC2, st, idx, lat, t);
    exp_data[3] = 8'hC2;
    vectors++;
    if (st !== S_UPD || idx !== 3'd3 || lat !== exp_lat || tbl_data !== pack_data() || count !== 4'd8) begin
      miscompares++;
      $display("FAIL full_update: status=%b index=%0d lat=%0d count=%0d data=%h required 01/3/%0d/8/%h",
               st, idx, lat, count, tbl_data, exp_lat, pack_data());
    end
  endtask

  task automatic test_delete();
    logic [1:0] st; logic [2:0] idx; int lat; time t;
    do_cmd(1'b1, 4'h9, 8'h00, st, idx, lat, t);
    vectors++;
    if (st !== S_NF || idx !== 3'd0 || count !== 4'd8 || tbl_valid !== 8'hFF || lat !== 10) begin
      miscompares++;
      $display("FAIL delete_miss: status=%b index=%0d count=%0d valid=%h lat=%0d required 11/0/8/ff/10",
               st, idx, count, tbl_valid, lat);
    end
    do_cmd(1'b1, 4'h3, 8'h00, st, idx, lat, t);
    exp_valid[0] = 1'b0;
    vectors++;
    if (st !== S_UPD || idx !== 3'd0 || count !== 4'd7 || tbl_valid !== 8'hFE) begin
      miscompares++;
      $display("FAIL delete_hit: status=%b index=%0d count=%0d valid=%h required 01/0/7/fe",
               st, idx, count, tbl_valid);
    end
    vectors++;
    if (tbl_key !== pack_key() || tbl_data !== pack_data()) begin
      miscompares++;
      $display("FAIL delete_keeps_contents: key=%h data=%h required %h/%h", tbl_key, tbl_data, pack_key(), pack_data());
    end
    do_cmd(1'b0, 4'hA, 8'h77, st, idx, lat, t);
    exp_valid[0] = 1'b1; exp_key[0] = 4'hA; exp_data[0] = 8'h77;
    vectors++;
    if (st !== S_NEW || idx !== 3'd0 || count !== 4'd8 || tbl_valid !== 8'hFF || tbl_key !== pack_key()) begin
      miscompares++;
      $display("FAIL delete_reuse: status=%b index=%0d count=%0d valid=%h key=%h required 00/0/8/ff/%h",
               st, idx, count, tbl_valid, tbl_key, pack_key());
    end
  endtask

  task automatic test_busy();
    int pulses;
    logic [1:0] st;
    st = 2'b00;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_key = 4'hE; cmd_data = 8'h00;
    @(posedge clk);
    #1;
    // Same cycle stream now carries a different write that must be ignored
    cmd_op = 1'b0; cmd_key = 4'hB; cmd_data = 8'hBB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_ready_cycle%0d: cmd_ready=%b required 0", i, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        pulses++;
        st = rsp_status;
      end
    end
    vectors++;
    if (pulses !== 1 || st !== S_NF) begin
      miscompares++;
      $display("FAIL busy_single_rsp: pulses=%0d status=%b required 1/11", pulses, st);
    end
    vectors++;
    if (count !== 4'd8 || tbl_key !== pack_key() || tbl_data !== pack_data()) begin
      miscompares++;
      $display("FAIL busy_ignored: count=%0d key=%h data=%h required 8/%h/%h", count, tbl_key, tbl_data, pack_key(), pack_data());
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = 4'hC; cmd_data = 8'hCC;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0 || count !== 4'd0 || tbl_valid !== 8'h00 || tbl_key !== 32'h0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: pulses=%0d count=%0d valid=%h key=%h ready=%b required 0/0/00/0/1",
               pulses, count, tbl_valid, tbl_key, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] st1, st2; logic [2:0] i1, i2; int l1, l2; time t1, t2;
    do_cmd(1'b0, 4'h1, 8'h11, st1, i1, l1, t1);
    do_cmd(1'b0, 4'h2, 8'h22, st2, i2, l2, t2);
    exp_valid[1:0] = 2'b11;
    exp_key[0] = 4'h1; exp_data[0] = 8'h11;
    exp_key[1] = 4'h2; exp_data[1] = 8'h22;
    vectors++;
    if ((t2 - t1) !== 100) begin
      miscompares++;
      $display("FAIL b2b_throughput: accept spacing=%0t required 100 (10 cycles)", t2 - t1);
    end
    vectors++;
    if (st1 !== S_NEW || i1 !== 3'd0 || st2 !== S_NEW || i2 !== 3'd1 || count !== 4'd2) begin
      miscompares++;
      $display("FAIL b2b_rsp: %b/%0d then %b/%0d count=%0d required 00/0 then 00/1, 2", st1, i1, st2, i2, count);
    end
  endtask

  task automatic test_early_exit();
    logic [1:0] st; logic [2:0] idx; int lat; time t;
    int exp_lat;
    do_cmd(1'b0, 4'h5, 8'h55, st, idx, lat, t);
    exp_valid[2] = 1'b1; exp_key[2] = 4'h5; exp_data[2] = 8'h55;
    vectors++;
    if (st !== S_NEW || idx !== 3'd2 || lat !== 10) begin
      miscompares++;
      $display("FAIL miss_latency: status=%b index=%0d lat=%0d required 00/2/10", st, idx, lat);
    end
`ifdef CAM_TABLE_WRITER_EARLY_EXIT_EN
    exp_lat = 5;
`else
    exp_lat = 10;
`endif
    do_cmd(1'b0, 4'h5, 8'h66, st, idx, lat, t);
    exp_data[2] = 8'h66;
    vectors++;
    if (st !== S_UPD || idx !== 3'd2 || lat !== exp_lat || tbl_data !== pack_data() || tbl_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL hit_idx2: status=%b index=%0d lat=%0d data=%h required 01/2/%0d/%h",
               st, idx, lat, tbl_data, exp_lat, pack_data());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_write_new();
    test_update();
    test_full();
    test_delete();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_early_exit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cam_table_writer
`default_nettype wire
